// File: rtl/dot_product_loader.sv
// dot_product_loader: upstream sequencer for the 8-element dot-product accelerator.
// Collects 16 operand words (a0..a7, b0..b7) from a valid/ready stream into packed
// A/B buses, pulses acc_start, waits for acc_done and returns the 64-bit result
// on a valid/ready response port. A clear pulse aborts at any point; an op that
// was already started is drained so the accelerator is idle before the next start.
// Optional feature macro: DOTP_LOADER_TIMEOUT_EN adds a done watchdog that
// returns an error response (r_err=1, r_data=0) after TIMEOUT_CYCLES.
module dot_product_loader #(
    parameter int N_ELEM         = 8,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    output logic                 acc_start,
    output logic [N_ELEM*DW-1:0] acc_a,
    output logic [N_ELEM*DW-1:0] acc_b,
    input  logic                 acc_done,
    input  logic [63:0]          acc_result,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [63:0]          r_data,
    output logic                 r_err,
    output logic                 busy
);

    localparam int              IW       = $clog2(2 * N_ELEM);
    localparam logic [IW-1:0]   LAST_IDX = IW'(2 * N_ELEM - 1);
    localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                first_q, first_d;
    logic                acc_start_q, acc_start_d;
    logic                r_valid_q, r_valid_d;
    logic [63:0]         r_data_q, r_data_d;
    logic                r_err_q, r_err_d;
    logic                busy_q, busy_d;
    logic [N_ELEM*DW-1:0] acc_a_q, acc_b_q;
    logic                wr_en;
    logic                timeout;
    logic                done_seen;

    // acc_done is only trusted after the first cycle in WAIT/DRAIN, so a done
    // level left over from the previous op cannot be mistaken for this one.
    assign done_seen = acc_done & ~first_q;

`ifdef DOTP_LOADER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Watchdog counts cycles spent in WAIT/DRAIN, restarting on every state entry.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_WAIT) || (state_q == S_DRAIN)))
            cnt_d = cnt_q + 16'd1;
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && (cnt_q == TO_LAST);
`else
    logic unused_to;
    assign unused_to = ^TO_LAST;
    assign timeout   = 1'b0;
`endif

    // Next-state and output decode; clear takes priority over any handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en     = 1'b0;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_err_d   = r_err_q;
        unique case (state_q)
            S_LOAD: begin
                if (clear) begin
                    idx_d = '0;
                end else if (s_valid) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = clear ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (clear) begin
                    state_d = S_DRAIN;
                end else if (done_seen) begin
                    r_data_d  = acc_result;
                    r_err_d   = 1'b0;
                    r_valid_d = 1'b1;
                    state_d   = S_RESP;
                end else if (timeout) begin
                    r_data_d  = '0;
                    r_err_d   = 1'b1;
                    r_valid_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (clear || r_ready) begin
                    r_valid_d = 1'b0;
                    r_err_d   = 1'b0;
                    idx_d     = '0;
                    state_d   = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (done_seen || timeout) state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
        endcase
        acc_start_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_LOAD);
        first_d     = (state_d != state_q);
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            first_q     <= 1'b0;
            acc_start_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            acc_start_q <= acc_start_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_err_q     <= r_err_d;
            busy_q      <= busy_d;
        end
    end

    // Operand capture: word idx lands in A[idx] or B[idx-N_ELEM].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a_q <= '0;
            acc_b_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (idx_q == IW'(i))          acc_a_q[i*DW +: DW] <= s_data;
                if (idx_q == IW'(i + N_ELEM)) acc_b_q[i*DW +: DW] <= s_data;
            end
        end
    end

    assign s_ready   = rst_n & (state_q == S_LOAD);
    assign acc_start = acc_start_q;
    assign acc_a     = acc_a_q;
    assign acc_b     = acc_b_q;
    assign r_valid   = r_valid_q;
    assign r_data    = r_data_q;
    assign r_err     = r_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dot_product_loader.sv
// Testbench for dot_product_loader: drives a behavioural 8-cycle accelerator,
// applies a table of directed vectors plus random ops and checks every response
// against a dot product computed from the bench's own operand arrays.
module tb_dot_product_loader;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int TO = 64;

    typedef logic [31:0] vec_t [8];
    typedef struct {
        vec_t        a;
        vec_t        b;
        logic [63:0] exp;
    } vec_rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            acc_start;
    logic [N*DW-1:0] acc_a, acc_b;
    logic            acc_done;
    logic [63:0]     acc_result;
    logic            r_valid;
    logic            r_ready = 1'b0;
    logic [63:0]     r_data;
    logic            r_err;
    logic            busy;

    int errs = 0;
    int checks = 0;

    dot_product_loader #(.N_ELEM(N), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .acc_start(acc_start), .acc_a(acc_a), .acc_b(acc_b),
        .acc_done(acc_done), .acc_result(acc_result),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .r_err(r_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural accelerator ----------------
    // 8 run cycles after the start edge, then done held until the next start.
    // stub: never responds (done forced low). lazy: done drops one cycle late.
    logic        stub = 1'b0;
    logic        lazy = 1'b0;
    int          acnt;
    logic        done_m, lazy_pend;
    logic [63:0] pend_res;

    function automatic logic [63:0] dot_bus(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            int x, y;
            x = a[i*DW +: DW];
            y = b[i*DW +: DW];
            s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acnt <= 0; done_m <= 1'b0; acc_result <= '0; lazy_pend <= 1'b0; pend_res <= '0;
        end else begin
            lazy_pend <= 1'b0;
            if (lazy_pend) done_m <= 1'b0;
            if (acc_start && !stub && acnt == 0) begin
                acnt     <= 8;
                pend_res <= dot_bus(acc_a, acc_b);
                if (lazy) lazy_pend <= 1'b1;
                else      done_m    <= 1'b0;
            end else if (acnt > 0) begin
                acnt <= acnt - 1;
                if (acnt == 1) begin
                    done_m     <= 1'b1;
                    acc_result <= pend_res;
                end
            end
        end
    end
    assign acc_done = stub ? 1'b0 : done_m;

    // ---------------- reference model and helpers ----------------
    function automatic logic [63:0] dot_ref(input vec_t a, input vec_t b);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(int'(a[i])) * longint'(int'(b[i]));
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams all 16 words; returns right after the edge that accepts word 15.
    task automatic send_batch(input vec_t a, input vec_t b);
        for (int k = 0; k < 2 * N; k++) begin
            int n = 0;
            s_valid = 1'b1;
            s_data  = (k < N) ? a[k] : b[k-N];
            while (!s_ready && n < 200) begin tick(); n++; end
            if (n >= 200) chk("s_ready_timeout", 64'(n), 64'(0));
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input logic [63:0] exp, input int exp_lat);
        int n = 0;
        while (!r_valid && n < 200) begin tick(); n++; end
        chk({name, "_latency"}, 64'(n), 64'(exp_lat));
        chk({name, "_data"}, r_data, exp);
        chk({name, "_err"}, 64'(r_err), 64'(0));
    endtask

    task automatic accept_resp(input string name);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk({name, "_rvalid_drop"}, 64'(r_valid), 64'(0));
        chk({name, "_sready_back"}, 64'(s_ready), 64'(1));
    endtask

    task automatic run_op(input string name, input vec_t a, input vec_t b, input logic [63:0] exp);
        send_batch(a, b);
        wait_resp(name, exp, 10);
        accept_resp(name);
    endtask

    // ---------------- test sequence ----------------
    vec_rec_t tbl[4];

    initial begin
        vec_t ra, rb, za;
        logic [63:0] hold_d;
        logic [N*DW-1:0] hold_a;
        logic ok, saw_rv, busy_bad;
        int n;

        for (int i = 0; i < N; i++) begin
            tbl[0].a[i] = 32'(i + 1);     tbl[0].b[i] = 32'(i + 1);
            tbl[1].a[i] = 32'hFFFF_FFFF;  tbl[1].b[i] = 32'(i + 1);
            tbl[2].a[i] = 32'h8000_0000;  tbl[2].b[i] = 32'h8000_0000;
            tbl[3].a[i] = (i == 0) ? 32'h8000_0000 : 32'h0;
            tbl[3].b[i] = (i == 0) ? 32'h8000_0000 : 32'h0;
            za[i] = 32'(i * 3 + 5);
        end
        tbl[0].exp = 64'd204;
        tbl[1].exp = 64'hFFFF_FFFF_FFFF_FFDC;
        tbl[2].exp = 64'h0;
        tbl[3].exp = 64'h4000_0000_0000_0000;

        // Reset state
        #2;
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_outputs", {acc_start, r_valid, r_err, busy}, '0);
        chk("rst_acc_a", 64'(|acc_a | |acc_b), 64'(0));
        chk("rst_r_data", r_data, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));
        chk("post_rst_busy", 64'(busy), 64'(0));

        // Directed table
        for (int t = 0; t < 4; t++) begin
            send_batch(tbl[t].a, tbl[t].b);
            chk($sformatf("tbl%0d_busy", t), 64'(busy), 64'(1));
            wait_resp($sformatf("tbl%0d", t), tbl[t].exp, 10);
            if (t == 0) begin
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("pack_a%0d", i), 64'(acc_a[i*DW +: DW]), 64'(tbl[0].a[i]));
                    chk($sformatf("pack_b%0d", i), 64'(acc_b[i*DW +: DW]), 64'(tbl[0].b[i]));
                end
            end
            accept_resp($sformatf("tbl%0d", t));
        end

        // Random ops with random response back-pressure
        for (int t = 0; t < 6; t++) begin
            int d;
            for (int i = 0; i < N; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
            send_batch(ra, rb);
            wait_resp($sformatf("rnd%0d", t), dot_ref(ra, rb), 10);
            d = $urandom_range(0, 3);
            repeat (d) tick();
            chk($sformatf("rnd%0d_hold", t), r_data, dot_ref(ra, rb));
            accept_resp($sformatf("rnd%0d", t));
        end

        // Response back-pressure for 20 cycles; next batch held off meanwhile
        send_batch(tbl[1].a, tbl[1].b);
        wait_resp("bp", tbl[1].exp, 10);
        hold_d = r_data; hold_a = acc_a; ok = 1'b1;
        s_valid = 1'b1; s_data = tbl[0].a[0];
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!r_valid || r_data !== hold_d || s_ready || acc_a !== hold_a) ok = 1'b0;
        end
        chk("bp_stable_20", 64'(ok), 64'(1));
        r_ready = 1'b1; tick(); r_ready = 1'b0;
        chk("bp_rvalid_drop", 64'(r_valid), 64'(0));
        run_op("bp_next", tbl[0].a, tbl[0].b, tbl[0].exp);

        // Clear two cycles into S_WAIT: drain, no response, then normal op
        send_batch(tbl[1].a, tbl[1].b);
        tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        n = 0; saw_rv = 1'b0; busy_bad = 1'b0;
        while (!s_ready && n < 100) begin
            if (r_valid) saw_rv = 1'b1;
            if (!busy) busy_bad = 1'b1;
            tick(); n++;
        end
        chk("drain_no_rvalid", 64'(saw_rv | r_valid), 64'(0));
        chk("drain_busy", 64'(busy_bad), 64'(0));
        chk("drain_cycles", 64'(n), 64'(7));
        run_op("after_drain", tbl[0].a, tbl[0].b, tbl[0].exp);

        // Clear in S_LOAD with a simultaneous handshake: partial words discarded
        send_batch(za, za);  // full op to keep it simple? no: partial below
        wait_resp("za", dot_ref(za, za), 10);
        accept_resp("za");
        for (int k = 0; k < 5; k++) begin s_valid = 1'b1; s_data = 32'hDEAD_0000 + 32'(k); tick(); end
        s_data = 32'h1234_5678; clear = 1'b1; tick(); clear = 1'b0; s_valid = 1'b0;
        chk("clr_load_sready", 64'(s_ready), 64'(1));
        run_op("clr_load", tbl[1].a, tbl[1].b, tbl[1].exp);

        // Clear in S_RESP together with r_ready
        send_batch(tbl[3].a, tbl[3].b);
        wait_resp("clr_resp", tbl[3].exp, 10);
        clear = 1'b1; r_ready = 1'b1; tick(); clear = 1'b0; r_ready = 1'b0;
        chk("clr_resp_rvalid", 64'(r_valid), 64'(0));
        chk("clr_resp_sready", 64'(s_ready), 64'(1));
        run_op("after_clr_resp", tbl[0].a, tbl[0].b, tbl[0].exp);

        // Stale done still high in the first S_WAIT cycle must be ignored
        lazy = 1'b1;
        run_op("stale_done", tbl[1].a, tbl[1].b, tbl[1].exp);
        lazy = 1'b0;

        // Accelerator never answers
        stub = 1'b1;
        send_batch(tbl[0].a, tbl[0].b);
`ifdef DOTP_LOADER_TIMEOUT_EN
        n = 0;
        while (!r_valid && n < TO + 20) begin tick(); n++; end
        chk("to_window", 64'(n >= TO && n <= TO + 4), 64'(1));
        chk("to_err", 64'(r_err), 64'(1));
        chk("to_data", r_data, '0);
        accept_resp("to");
        chk("to_err_clear", 64'(r_err), 64'(0));
        stub = 1'b0;
`else
        saw_rv = 1'b0; busy_bad = 1'b0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (r_valid) saw_rv = 1'b1;
            if (!busy) busy_bad = 1'b1;
        end
        chk("stub_no_rvalid", 64'(saw_rv), 64'(0));
        chk("stub_busy", 64'(busy_bad), 64'(0));
        chk("stub_r_err", 64'(r_err), 64'(0));
        stub = 1'b0;
        #3 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
`endif

        // Asynchronous reset mid-S_LOAD: outputs clear without a clock edge
        for (int k = 0; k < 5; k++) begin s_valid = 1'b1; s_data = 32'hA5A5_0000 + 32'(k); tick(); end
        s_valid = 1'b0;
        chk("pre_rst_acc_a_loaded", 64'(acc_a[DW-1:0]), 64'(32'hA5A5_0000));
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_s_ready", 64'(s_ready), 64'(0));
        chk("async_rst_acc", 64'(|acc_a | |acc_b), 64'(0));
        chk("async_rst_ctrl", {acc_start, r_valid, r_err, busy}, '0);
        chk("async_rst_r_data", r_data, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        run_op("after_rst", tbl[0].a, tbl[0].b, tbl[0].exp);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        errs++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1);
    end

endmodule
